// File: rtl/byte_queue.sv
// byte_queue: synchronous ready/valid FIFO buffering bytes from a bursty
// producer and presenting them in order on a decoupled output.
// Ports:
//   clock, reset (synchronous, active-low)
//   io_enq_valid/io_enq_ready/io_enq_bits : producer side
//   io_deq_valid/io_deq_ready/io_deq_bits : consumer side (bits 0 when empty)
//   io_count                              : occupancy 0..DEPTH
// All outputs depend on registered state only; there is no input-to-output path.
module byte_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             io_enq_valid,
  output logic                             io_enq_ready,
  input  logic [WIDTH-1:0]                 io_enq_bits,
  output logic                             io_deq_valid,
  input  logic                             io_deq_ready,
  output logic [WIDTH-1:0]                 io_deq_bits,
  output logic [$clog2(DEPTH+1)-1:0]       io_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wp_q, wp_d;
  logic [PW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             enq_fire;
  logic             deq_fire;

  // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two)
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Outputs from registered state
  always_comb begin
    io_enq_ready = (count_q != CW'(DEPTH));
    io_deq_valid = (count_q != '0);
    io_deq_bits  = io_deq_valid ? mem_q[rp_q] : '0;
    io_count     = count_q;
  end

  // Handshakes, pointer and occupancy next-state
  always_comb begin
    mem_d    = mem_q;
    wp_d     = wp_q;
    rp_d     = rp_q;
    count_d  = count_q;
    enq_fire = io_enq_valid & io_enq_ready;
    deq_fire = io_deq_valid & io_deq_ready;

    if (enq_fire) begin
      mem_d[wp_q] = io_enq_bits;
      wp_d        = next_ptr(wp_q);
    end
    if (deq_fire) begin
      rp_d = next_ptr(rp_q);
    end

    case ({enq_fire, deq_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; cleared synchronously while reset is low
  always_ff @(posedge clock) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; writes are suppressed during reset
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_byte_queue.sv
// Self-checking bench for byte_queue: a DEPTH=4 and a DEPTH=3 instance are
// driven by directed steps and random traffic and compared against a
// queue-based reference model.
module tb_byte_queue;

  logic       clock = 1'b0;
  always #5 clock = ~clock;

  // DUT 0 : DEPTH=4
  logic       rn0, ev0, er0, dv0, dr0;
  logic [7:0] eb0, db0;
  logic [2:0] cnt0;
  // DUT 1 : DEPTH=3
  logic       rn1, ev1, er1, dv1, dr1;
  logic [7:0] eb1, db1;
  logic [1:0] cnt1;

  byte_queue #(.DEPTH(4), .WIDTH(8)) u_dut0 (
    .clock(clock), .reset(rn0),
    .io_enq_valid(ev0), .io_enq_ready(er0), .io_enq_bits(eb0),
    .io_deq_valid(dv0), .io_deq_ready(dr0), .io_deq_bits(db0),
    .io_count(cnt0)
  );

  byte_queue #(.DEPTH(3), .WIDTH(8)) u_dut1 (
    .clock(clock), .reset(rn1),
    .io_enq_valid(ev1), .io_enq_ready(er1), .io_enq_bits(eb1),
    .io_deq_valid(dv1), .io_deq_ready(dr1), .io_deq_bits(db1),
    .io_count(cnt1)
  );

  // Reference model: one queue per instance, plus a log of dequeued bytes
  logic [7:0] mq0[$];
  logic [7:0] mq1[$];
  logic [7:0] got[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=0x%0h expected=0x%0h", tag, d, obs, exp);
    end
  endtask

  function automatic int msize(input int d);
    return (d == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [31:0] obs_count(input int d);
    return (d == 0) ? 32'(cnt0) : 32'(cnt1);
  endfunction

  // Compare all outputs of instance d against the model
  task automatic check_outputs(input int d);
    int         sz, dep;
    logic [7:0] head;
    sz   = msize(d);
    dep  = (d == 0) ? 4 : 3;
    head = 8'h00;
    if (sz > 0) head = (d == 0) ? mq0[0] : mq1[0];
    chk("count", d, obs_count(d), 32'(sz));
    chk("deq_valid", d, (d == 0) ? 32'(dv0) : 32'(dv1), 32'(sz != 0));
    chk("deq_bits", d, (d == 0) ? 32'(db0) : 32'(db1), 32'(head));
    chk("enq_ready", d, (d == 0) ? 32'(er0) : 32'(er1), 32'(sz != dep));
  endtask

  // One clock cycle on instance d: check, drive, advance model after the edge
  task automatic step(input int d, input logic ev, input logic [7:0] eb, input logic dr);
    int         sz, dep;
    logic       ef, df;
    logic [7:0] popped;
    check_outputs(d);
    if (d == 0) begin ev0 = ev; eb0 = eb; dr0 = dr; end
    else        begin ev1 = ev; eb1 = eb; dr1 = dr; end
    sz  = msize(d);
    dep = (d == 0) ? 4 : 3;
    ef  = ev && (sz < dep);
    df  = dr && (sz > 0);
    @(posedge clock);
    if (df) begin
      popped = (d == 0) ? mq0.pop_front() : mq1.pop_front();
      got.push_back(popped);
    end
    if (ef) begin
      if (d == 0) mq0.push_back(eb);
      else        mq1.push_back(eb);
    end
    #1;
    if (d == 0) begin ev0 = 1'b0; dr0 = 1'b0; end
    else        begin ev1 = 1'b0; dr1 = 1'b0; end
  endtask

  // Hold reset low for n edges while offering 0xAA with consumer ready
  task automatic do_reset(input int d, input int n);
    if (d == 0) begin rn0 = 1'b0; ev0 = 1'b1; eb0 = 8'hAA; dr0 = 1'b1; end
    else        begin rn1 = 1'b0; ev1 = 1'b1; eb1 = 8'hAA; dr1 = 1'b1; end
    repeat (n) @(posedge clock);
    #1;
    if (d == 0) begin mq0.delete(); rn0 = 1'b1; ev0 = 1'b0; dr0 = 1'b0; end
    else        begin mq1.delete(); rn1 = 1'b1; ev1 = 1'b0; dr1 = 1'b0; end
  endtask

  initial begin
    logic [7:0] exp_drain [4];
    rn0 = 1'b0; ev0 = 1'b0; eb0 = 8'h00; dr0 = 1'b0;
    rn1 = 1'b0; ev1 = 1'b0; eb1 = 8'h00; dr1 = 1'b0;
    #1;

    // Reset with a pending enqueue of 0xAA; nothing may be stored
    do_reset(1, 2);
    do_reset(0, 2);
    chk("rst_count", 0, 32'(cnt0), 32'd0);
    chk("rst_deq_valid", 0, 32'(dv0), 32'd0);
    chk("rst_deq_bits", 0, 32'(db0), 32'h00);
    chk("rst_enq_ready", 0, 32'(er0), 32'd1);
    chk("rst_count", 1, 32'(cnt1), 32'd0);

    // Fill to full with consumer stalled; 0x55 offered at full is dropped
    step(0, 1'b1, 8'h11, 1'b0);
    chk("fill_count1", 0, 32'(cnt0), 32'd1);
    step(0, 1'b1, 8'h22, 1'b0);
    step(0, 1'b1, 8'h33, 1'b0);
    step(0, 1'b1, 8'h44, 1'b0);
    chk("fill_count4", 0, 32'(cnt0), 32'd4);
    chk("fill_ready0", 0, 32'(er0), 32'd0);
    step(0, 1'b1, 8'h55, 1'b0);
    chk("full_hold_count", 0, 32'(cnt0), 32'd4);
    chk("full_hold_bits", 0, 32'(db0), 32'h11);

    // Drain: 0x11..0x44 on consecutive cycles, then empty
    got.delete();
    exp_drain[0] = 8'h11; exp_drain[1] = 8'h22;
    exp_drain[2] = 8'h33; exp_drain[3] = 8'h44;
    repeat (4) step(0, 1'b0, 8'h00, 1'b1);
    chk("drain_len", 0, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk("drain_order", 0, 32'(got[i]), 32'(exp_drain[i]));
    end
    chk("drain_valid", 0, 32'(dv0), 32'd0);
    chk("drain_bits", 0, 32'(db0), 32'h00);
    step(0, 1'b0, 8'h00, 1'b1);

    // Full queue with both sides active: dequeue happens, enqueue refused
    for (int i = 0; i < 4; i++) step(0, 1'b1, 8'(8'hB0 + i), 1'b0);
    step(0, 1'b1, 8'h66, 1'b1);
    chk("fullboth_count", 0, 32'(cnt0), 32'd3);
    chk("fullboth_ready", 0, 32'(er0), 32'd1);
    chk("fullboth_head", 0, 32'(db0), 32'hB1);
    repeat (3) step(0, 1'b0, 8'h00, 1'b1);

    // Streaming at count 2 across pointer wrap
    step(0, 1'b1, 8'hE0, 1'b0);
    step(0, 1'b1, 8'hE1, 1'b0);
    got.delete();
    for (int i = 1; i <= 10; i++) begin
      step(0, 1'b1, 8'(i), 1'b1);
      chk("stream_count", 0, 32'(cnt0), 32'd2);
    end
    chk("stream_first", 0, 32'(got[0]), 32'hE0);
    chk("stream_third", 0, 32'(got[2]), 32'h01);
    chk("stream_last", 0, 32'(got[9]), 32'h08);

    // Reset mid-operation discards queued bytes
    do_reset(0, 1);
    step(0, 1'b1, 8'h77, 1'b0);
    chk("post_rst_head", 0, 32'(db0), 32'h77);
    chk("post_rst_count", 0, 32'(cnt0), 32'd1);

    // DEPTH=3: 7 bytes through, wrapping 2->0
    step(1, 1'b1, 8'hA0, 1'b0);
    got.delete();
    for (int i = 1; i <= 6; i++) begin
      step(1, 1'b1, 8'(8'hA0 + i), 1'b1);
      chk("d3_count", 1, 32'(cnt1), 32'd1);
    end
    step(1, 1'b0, 8'h00, 1'b1);
    chk("d3_len", 1, 32'(got.size()), 32'd7);
    for (int i = 0; i < 7; i++) begin
      if (i < got.size()) chk("d3_order", 1, 32'(got[i]), 32'(8'hA0 + i));
    end
    for (int i = 0; i < 4; i++) step(1, 1'b1, 8'(8'hC0 + i), 1'b0);
    chk("d3_full_count", 1, 32'(cnt1), 32'd3);
    chk("d3_full_ready", 1, 32'(er1), 32'd0);

    // Random traffic on both instances with occasional reset
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 400; n++) begin
        if ($urandom_range(0, 79) == 0) begin
          do_reset(d, 1);
        end else begin
          step(d, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0 ? 1 : 0));
        end
        chk("rand_count_bound", d, 32'(obs_count(d) <= 32'((d == 0) ? 4 : 3)), 32'd1);
      end
      check_outputs(d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/byte_queue.md
Name: byte_queue

Overview:
- Synchronous ready/valid byte FIFO that sits directly upstream of the 8-bit passthrough stage.
- Buffers bytes from a bursty producer and presents them one at a time on a decoupled output; the output's bits feed the passthrough's io_in.
- Decouples producer and consumer timing; carries no data transformation.

Parameters:
- DEPTH, 4, number of storage entries; any integer >= 2; power of two not required.
- WIDTH, 8, data width in bits; matches the passthrough datapath.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset); sampled on rising edge of clock.
- io_enq_valid  input  1  producer has a byte on io_enq_bits.
- io_enq_ready  output  1  queue can accept a byte this cycle.
- io_enq_bits  input  WIDTH  enqueue data.
- io_deq_valid  output  1  io_deq_bits holds the oldest stored byte.
- io_deq_ready  input  1  consumer takes the byte this cycle.
- io_deq_bits  output  WIDTH  head-of-queue data; forced to 0 when empty.
- io_count  output  clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- State: storage array mem[DEPTH], write pointer wp, read pointer rp, occupancy count.
- Reset:
  - On a rising edge with reset=0: wp, rp and count are set to 0. Storage contents are not cleared.
  - Any handshake in that cycle is ignored.
  - From the following cycle: io_count=0, io_deq_valid=0, io_deq_bits=0, io_enq_ready=1.
- Outputs are pure functions of registered state; there is no combinational path from any input to any output:
  - io_enq_ready = (count != DEPTH)
  - io_deq_valid = (count != 0)
  - io_deq_bits = mem[rp] when count != 0, else 0
  - io_count = count
- Enqueue fires when io_enq_valid & io_enq_ready. On that edge: mem[wp] <= io_enq_bits, and wp advances.
- Dequeue fires when io_deq_valid & io_deq_ready. On that edge, rp advances.
- Pointer wrap: a pointer at DEPTH-1 advances to 0; otherwise it increments by 1.
- Count update:
  - Enqueue only: +1.
  - Dequeue only: -1.
  - Both, or neither: unchanged.
- Latency: a byte accepted on edge N appears on io_deq_bits and raises io_deq_valid from edge N+1. There is no fall-through when empty.
- Full (count=DEPTH):
  - io_enq_ready=0, so io_enq_valid is ignored.
  - A dequeue in the same cycle frees an entry, and io_enq_ready rises next cycle. Ready does not pass through combinationally.
- Empty (count=0): io_deq_valid=0, and io_deq_ready is ignored.
- Simultaneous enqueue and dequeue with 0<count<DEPTH: both pointers advance and count holds. The head byte read this cycle is the pre-edge mem[rp].
- Stability: while io_deq_valid=1 and io_deq_ready=0, io_deq_bits holds its value, regardless of enqueue activity.
- Ordering: strict FIFO. No byte is dropped or duplicated.
- Reset mid-operation: all queued bytes are discarded. The first post-reset dequeue returns only data enqueued after reset.
- Data width: WIDTH bits, no truncation or extension.

Test Plan:
- Reset low for 2 cycles with io_enq_valid=1, io_enq_bits=0xAA -> after release: io_count=0, io_deq_valid=0, io_deq_bits=0x00, io_enq_ready=1; 0xAA is never dequeued.
- Fill (DEPTH=4) with 0x11,0x22,0x33,0x44 and io_deq_ready=0 -> io_count steps 1,2,3,4; io_enq_ready=0 at count 4; 0x55 offered at full is ignored; io_deq_bits stays 0x11.
- Drain the full queue with io_deq_ready=1 -> outputs 0x11,0x22,0x33,0x44 on consecutive cycles; then io_deq_valid=0, io_deq_bits=0x00, io_count=0.
- Continuous enqueue and dequeue for 10 bytes 0x01..0x0A starting at count 2 -> count stays 2; output order preserved across pointer wrap; no loss.
- Full queue with both io_enq_valid=1 and io_deq_ready=1 -> the dequeue occurs, the enqueue is rejected that cycle, and io_enq_ready=1 the next cycle with count=3.
- DEPTH=3 build: enqueue and dequeue 7 bytes 0xA0..0xA6 -> pointers wrap 2->0 correctly; FIFO order intact; io_count never exceeds 3.
